// File: rtl/mem_arb_pkg.sv
// Shared encodings and counter widths for the two-requester memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_F = 2'd1,
        OWN_E = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_F    = 2'b01;
    localparam logic [1:0] GNT_E    = 2'b10;

    localparam int STARVE_W = 4;
    localparam int LOCK_W   = 4;
    localparam int TMO_W    = 8;

endpackage

// File: rtl/mem_arb_timeout.sv
// OWN-state watchdog for mem_arbiter: reloads while idle, counts down while the bus is owned.
// Only built when MEM_TIMEOUT_EN is defined.
`ifdef MEM_TIMEOUT_EN
module mem_arb_timeout
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic count_i,
    output logic expired_o
);

    localparam logic [TMO_W-1:0] LOAD_VAL = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (count_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= LOAD_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Zero is reached during the TIMEOUT_CYCLES-th owned cycle.
    assign expired_o = count_i && (cnt_q == '0);

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Fetch/exec arbiter and sequencer for the single 8-bit memory bus, with starvation guard
// and fetch bus lock. Optional OWN-state timeout abort enabled by MEM_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | bus free, winner picked at the clock edge
//   OWN_F | fetch owns the bus, waiting for mem_ready
//   OWN_E | exec owns the bus, waiting for mem_ready
//   DONE  | dead cycle, x_ready pulse visible, requests ignored
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_MAX     = 2
`ifdef MEM_TIMEOUT_EN
    ,parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       f_req,
    input  logic [7:0] f_addr,
    input  logic       f_lock,
    output logic       f_ready,
    output logic [7:0] f_rdata,
    input  logic       e_req,
    input  logic       e_we,
    input  logic [7:0] e_addr,
    input  logic [7:0] e_wdata,
    output logic       e_ready,
    output logic [7:0] e_rdata,
    output logic       f_err,
    output logic       e_err,
    output logic [1:0] grant,
    output logic       mem_req,
    output logic [7:0] addr,
    output logic       we,
    inout  wire  [7:0] data,
    input  logic       mem_ready
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_LIMIT);
    localparam logic [LOCK_W-1:0]   LOCK_LAST  = LOCK_W'(LOCK_MAX - 1);

    arb_state_e          state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic [7:0]          addr_q, addr_d;
    logic                we_q, we_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [1:0]          grant_q, grant_d;
    logic                f_ready_q, f_ready_d;
    logic                e_ready_q, e_ready_d;
    logic [7:0]          f_rdata_q, f_rdata_d;
    logic [7:0]          e_rdata_q, e_rdata_d;
    logic                f_err_q, f_err_d;
    logic                e_err_q, e_err_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [LOCK_W-1:0]   beats_q, beats_d;
    logic                lock_q, lock_d;
    logic                pick_f, pick_e;
    logic                tmo_expired;

`ifdef MEM_TIMEOUT_EN
    logic tmo_load, tmo_count;

    assign tmo_load  = (state_q == IDLE);
    assign tmo_count = (state_q == OWN_F) || (state_q == OWN_E);

    mem_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .load_i   (tmo_load),
        .count_i  (tmo_count),
        .expired_o(tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        mem_req_d = mem_req_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        grant_d   = grant_q;
        f_ready_d = 1'b0;
        e_ready_d = 1'b0;
        f_err_d   = 1'b0;
        e_err_d   = 1'b0;
        f_rdata_d = f_rdata_q;
        e_rdata_d = e_rdata_q;
        starve_d  = starve_q;
        beats_d   = beats_q;
        lock_d    = lock_q;
        pick_f    = 1'b0;
        pick_e    = 1'b0;

        case (state_q)
            IDLE: begin
                if (lock_q && f_req) begin
                    pick_f = 1'b1;
                end else begin
                    // A lock whose owner went away is dropped before normal priority applies.
                    if (lock_q) begin
                        lock_d  = 1'b0;
                        beats_d = '0;
                    end
                    if (e_req && (starve_q < STARVE_LIM)) begin
                        pick_e = 1'b1;
                    end else if (f_req) begin
                        pick_f = 1'b1;
                    end
                end

                if (pick_f) begin
                    state_d   = OWN_F;
                    mem_req_d = 1'b1;
                    addr_d    = f_addr;
                    we_d      = 1'b0;
                    grant_d   = GNT_F;
                    starve_d  = '0;
                    lock_d    = 1'b0;
                end else if (pick_e) begin
                    state_d   = OWN_E;
                    mem_req_d = 1'b1;
                    addr_d    = e_addr;
                    we_d      = e_we;
                    wdata_d   = e_wdata;
                    grant_d   = GNT_E;
                    beats_d   = '0;
                    if (f_req) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end
            end

            OWN_F, OWN_E: begin
                if (mem_ready || tmo_expired) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    we_d      = 1'b0;
                    grant_d   = GNT_NONE;
                    if (state_q == OWN_F) begin
                        f_ready_d = 1'b1;
                    end else begin
                        e_ready_d = 1'b1;
                    end
                end

                if (mem_ready) begin
                    if (state_q == OWN_F) begin
                        f_rdata_d = data;
                        // A fetch that does not extend the lock ends the locked run.
                        if (f_lock && (beats_q < LOCK_LAST)) begin
                            lock_d  = 1'b1;
                            beats_d = beats_q + LOCK_W'(1);
                        end else begin
                            beats_d = '0;
                        end
                    end else if (!we_q) begin
                        e_rdata_d = data;
                    end
                end else if (tmo_expired) begin
                    if (state_q == OWN_F) begin
                        f_err_d   = 1'b1;
                        f_rdata_d = 8'hFF;
                    end else begin
                        e_err_d   = 1'b1;
                        e_rdata_d = 8'hFF;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            addr_q    <= 8'h00;
            we_q      <= 1'b0;
            wdata_q   <= 8'h00;
            grant_q   <= GNT_NONE;
            f_ready_q <= 1'b0;
            e_ready_q <= 1'b0;
            f_rdata_q <= 8'h00;
            e_rdata_q <= 8'h00;
            f_err_q   <= 1'b0;
            e_err_q   <= 1'b0;
            starve_q  <= '0;
            beats_q   <= '0;
            lock_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            grant_q   <= grant_d;
            f_ready_q <= f_ready_d;
            e_ready_q <= e_ready_d;
            f_rdata_q <= f_rdata_d;
            e_rdata_q <= e_rdata_d;
            f_err_q   <= f_err_d;
            e_err_q   <= e_err_d;
            starve_q  <= starve_d;
            beats_q   <= beats_d;
            lock_q    <= lock_d;
        end
    end

    assign data    = we_q ? wdata_q : 8'hzz;
    assign mem_req = mem_req_q;
    assign addr    = addr_q;
    assign we      = we_q;
    assign grant   = grant_q;
    assign f_ready = f_ready_q;
    assign e_ready = e_ready_q;
    assign f_rdata = f_rdata_q;
    assign e_rdata = e_rdata_q;
    assign f_err   = f_err_q;
    assign e_err   = e_err_q;

endmodule
